mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Two-master to one-slave AXI4-style request arbiter.
- Merges the instruction-fetch read port (IFU) and the load/store port (LSU, read and write) into the single upstream port of the address-translation unit.
- Attaches the current satp to every accepted request.
- Holds at most one transaction in flight. It owns every out_* valid/ready; response data is routed back only to the granted master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Write strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- satp  in  32  current satp CSR value, sampled at grant
- ifu_araddr/ifu_arlen/ifu_arsize/ifu_arburst  in  32/8/3/2  IFU read address bundle
- ifu_arvalid  in  1;  ifu_arready  out  1
- ifu_rdata/ifu_rresp/ifu_rlast  out  32/2/1  IFU read data bundle
- ifu_rvalid  out  1;  ifu_rready  in  1
- lsu_araddr/lsu_arsize  in  32/3  LSU read address; arlen forced 0, arburst forced 2'b01
- lsu_arvalid  in  1;  lsu_arready  out  1
- lsu_rdata/lsu_rresp  out  32/2;  lsu_rvalid  out  1;  lsu_rready  in  1
- lsu_awaddr/lsu_wdata/lsu_wstrb  in  32/32/4  LSU write bundle
- lsu_awvalid/lsu_wvalid  in  1/1;  lsu_awready/lsu_wready  out  1/1
- lsu_bresp  out  2;  lsu_bvalid  out  1;  lsu_bready  in  1
- out_araddr/out_arlen/out_arsize/out_arburst/out_arsatp  out  32/8/3/2/32  to MMU read address
- out_arvalid  out  1;  out_arready  in  1
- out_rdata/out_rresp/out_rlast  in  32/2/1;  out_rvalid  in  1;  out_rready  out  1
- out_awaddr/out_awsatp/out_wdata/out_wstrb  out  32/32/32/4;  out_awvalid/out_wvalid  out  1/1
- out_awready/out_wready  in  1/1
- out_bresp  in  2;  out_bvalid  in  1;  out_bready  out  1

Behaviour:
- State machine states: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B. Reset state is IDLE.
- Reset values: all valid/ready outputs 0. Latched request registers (address, len, size, burst, satp, wdata, wstrb) are 0.
- IDLE, candidate requests: LSU write (lsu_awvalid && lsu_wvalid), LSU read (lsu_arvalid), IFU read (ifu_arvalid).
- IDLE, default priority: LSU write > LSU read > IFU.
- IDLE, on grant:
  - Latch the request fields and satp into registers.
  - Pulse the master's ready (arready, or awready+wready together) for exactly 1 cycle, on the grant cycle.
  - Go to IFU_AR, LSU_AR or LSU_W.
  - The grant cycle is registered: the out_*valid is asserted on the next cycle, never combinationally from master inputs.
- IFU_AR/LSU_AR: out_arvalid=1 with latched fields. On out_arready go to *_R. Payload stays stable while out_arvalid is high.
- IFU_R:
  - out_rready = ifu_rready, ifu_rvalid = out_rvalid; rdata/rresp/rlast pass through.
  - Return to IDLE on beat handshake with out_rlast=1. Supports arlen up to 255.
- LSU_R: pass-through as for IFU_R. Return to IDLE on the first handshake (single beat; rlast ignored).
- LSU_W:
  - out_awvalid and out_wvalid asserted together. Each drops independently on its own ready.
  - Go to LSU_B once both have handshaked, same cycle or different cycles.
- LSU_B: out_bready = lsu_bready, lsu_bvalid = out_bvalid, bresp passes through. On handshake go to IDLE.
- Non-granted master: ready/valid outputs held 0. Its rdata/rresp/rlast are don't-care but driven 0.
- out_arsatp and out_awsatp always equal the latched satp. A satp change mid-transaction does not affect the in-flight request.
- Simultaneous LSU read and write in IDLE: write wins. The read waits and is granted in the next IDLE cycle.
- LSU aw valid without w valid (or w without aw): not eligible. Wait until both are valid.
- Back-to-back: minimum 1 IDLE cycle between transactions.
- Reset mid-transaction: return to IDLE immediately and drop all valids. No response is forwarded.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: IFU-vs-LSU arbitration is round-robin. A 1-bit last_grant register, reset to IFU, gives priority to the other master on the next contention. Inside LSU, write still beats read.
- Undefined: fixed priority LSU write > LSU read > IFU. IFU may starve.

Test Plan:
- IFU read only, addr 0x8000_0000, arlen 3, satp 0x8008_0000:
  - out_araddr=0x8000_0000, out_arlen=3, out_arsatp=0x8008_0000 one cycle after ifu_arready pulse.
  - 4 data beats reach IFU; IDLE after the rlast beat.
- LSU write addr 0x8000_0010, wdata 0xDEADBEEF, wstrb 0xF; out_wready delayed 3 cycles after out_awready:
  - out_awvalid drops after aw handshake; out_wvalid held until w handshake.
  - lsu_bvalid mirrors out_bvalid; bresp 0 returned.
- IFU read and LSU read asserted in same cycle, macro off: LSU granted first, IFU granted in the IDLE cycle after the LSU response.
- Same contention repeated 4 times with ARB_RR_EN: grants alternate IFU, LSU, IFU, LSU.
- LSU write and LSU read in same IDLE cycle: write completes (B handshake), then read issued. lsu_arready never pulses before lsu_bvalid handshake.
- rst asserted while in IFU_R after 2 of 4 beats: next cycle all valid outputs 0 and state IDLE; fresh LSU read then completes normally.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave request arbiter with one transaction in flight.
// Optional macro ARB_RR_EN selects round-robin IFU-vs-LSU arbitration instead of fixed LSU priority.
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         satp,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_awvalid,
  input  logic                lsu_wvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ADDR_W-1:0]   out_araddr,
  output logic [7:0]          out_arlen,
  output logic [2:0]          out_arsize,
  output logic [1:0]          out_arburst,
  output logic [31:0]         out_arsatp,
  output logic                out_arvalid,
  input  logic                out_arready,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  input  logic                out_rlast,
  input  logic                out_rvalid,
  output logic                out_rready,
  output logic [ADDR_W-1:0]   out_awaddr,
  output logic [31:0]         out_awsatp,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_awvalid,
  output logic                out_wvalid,
  input  logic                out_awready,
  input  logic                out_wready,
  input  logic [1:0]          out_bresp,
  input  logic                out_bvalid,
  output logic                out_bready,
  output logic [2:0]          o_state
);

  // Handshake rule on every channel: a beat transfers on a rising clk edge where valid && ready;
  // a valid, once raised, keeps its payload stable until that transfer.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFU_AR = 3'd1,
    S_IFU_R  = 3'd2,
    S_LSU_AR = 3'd3,
    S_LSU_R  = 3'd4,
    S_LSU_W  = 3'd5,
    S_LSU_B  = 3'd6
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [31:0]         r_satp;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_arvalid;
  logic                r_awvalid;
  logic                r_wvalid;

  logic w_idle, w_wr_req, w_lsu_req, w_grant_ifu, w_grant_wr, w_grant_rd;
  logic w_ifu_r, w_lsu_r, w_lsu_b;

  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_wr_req  = lsu_awvalid && lsu_wvalid;
  assign w_lsu_req = w_wr_req || lsu_arvalid;

`ifdef ARB_RR_EN
  // 0 = IFU was granted last, 1 = LSU was granted last; the other side wins the next contention.
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) r_last_grant <= 1'b0;
    else if (w_grant_ifu) r_last_grant <= 1'b0;
    else if (w_grant_wr || w_grant_rd) r_last_grant <= 1'b1;
  end

  assign w_grant_ifu = w_idle && ifu_arvalid && (!w_lsu_req || r_last_grant);
`else
  assign w_grant_ifu = w_idle && ifu_arvalid && !w_lsu_req;
`endif
  assign w_grant_wr  = w_idle && w_wr_req && !w_grant_ifu;
  assign w_grant_rd  = w_idle && lsu_arvalid && !w_wr_req && !w_grant_ifu;

  assign ifu_arready = w_grant_ifu;
  assign lsu_arready = w_grant_rd;
  assign lsu_awready = w_grant_wr;
  assign lsu_wready  = w_grant_wr;

  assign out_araddr  = r_addr;
  assign out_arlen   = r_len;
  assign out_arsize  = r_size;
  assign out_arburst = r_burst;
  assign out_arsatp  = r_satp;
  assign out_arvalid = r_arvalid;
  assign out_awaddr  = r_addr;
  assign out_awsatp  = r_satp;
  assign out_wdata   = r_wdata;
  assign out_wstrb   = r_wstrb;
  assign out_awvalid = r_awvalid;
  assign out_wvalid  = r_wvalid;
  assign o_state     = r_state;

  // Response channels are routed only to the granted master and suppressed while in reset.
  assign w_ifu_r = (r_state == S_IFU_R) && !rst;
  assign w_lsu_r = (r_state == S_LSU_R) && !rst;
  assign w_lsu_b = (r_state == S_LSU_B) && !rst;

  assign out_rready = (w_ifu_r && ifu_rready) || (w_lsu_r && lsu_rready);
  assign ifu_rvalid = w_ifu_r && out_rvalid;
  assign ifu_rdata  = w_ifu_r ? out_rdata : '0;
  assign ifu_rresp  = w_ifu_r ? out_rresp : 2'b00;
  assign ifu_rlast  = w_ifu_r && out_rlast;
  assign lsu_rvalid = w_lsu_r && out_rvalid;
  assign lsu_rdata  = w_lsu_r ? out_rdata : '0;
  assign lsu_rresp  = w_lsu_r ? out_rresp : 2'b00;
  assign out_bready = w_lsu_b && lsu_bready;
  assign lsu_bvalid = w_lsu_b && out_bvalid;
  assign lsu_bresp  = w_lsu_b ? out_bresp : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_satp    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_addr    <= lsu_awaddr;
            r_wdata   <= lsu_wdata;
            r_wstrb   <= lsu_wstrb;
            r_len     <= 8'd0;
            r_burst   <= 2'b01;
            r_satp    <= satp;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_LSU_W;
          end else if (w_grant_rd) begin
            r_addr    <= lsu_araddr;
            r_len     <= 8'd0;
            r_size    <= lsu_arsize;
            r_burst   <= 2'b01;
            r_satp    <= satp;
            r_arvalid <= 1'b1;
            r_state   <= S_LSU_AR;
          end else if (w_grant_ifu) begin
            r_addr    <= ifu_araddr;
            r_len     <= ifu_arlen;
            r_size    <= ifu_arsize;
            r_burst   <= ifu_arburst;
            r_satp    <= satp;
            r_arvalid <= 1'b1;
            r_state   <= S_IFU_AR;
          end
        end
        S_IFU_AR, S_LSU_AR: begin
          if (out_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= (r_state == S_IFU_AR) ? S_IFU_R : S_LSU_R;
          end
        end
        S_IFU_R: if (out_rvalid && ifu_rready && out_rlast) r_state <= S_IDLE;
        S_LSU_R: if (out_rvalid && lsu_rready) r_state <= S_IDLE;
        S_LSU_W: begin
          if (out_awready) r_awvalid <= 1'b0;
          if (out_wready) r_wvalid <= 1'b0;
          // AW and W may complete in either order or together.
          if ((!r_awvalid || out_awready) && (!r_wvalid || out_wready)) r_state <= S_LSU_B;
        end
        S_LSU_B: if (out_bvalid && lsu_bready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reads, writes, contention, write-before-read and mid-burst reset.
// The expected grant order follows ARB_RR_EN when the bench is built with that macro.
module tb_mem_req_arbiter;

  logic        clk, rst;
  logic [31:0] satp;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_awvalid, lsu_wvalid, lsu_awready, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] out_araddr;
  logic [7:0]  out_arlen;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
  logic [31:0] out_arsatp;
  logic        out_arvalid, out_arready;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic        out_rlast, out_rvalid, out_rready;
  logic [31:0] out_awaddr, out_awsatp, out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_awvalid, out_wvalid, out_awready, out_wready;
  logic [1:0]  out_bresp;
  logic        out_bvalid, out_bready;
  logic [2:0]  o_state;

  int n_total = 0;
  int n_bad   = 0;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .satp(satp),
    .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
    .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_awvalid(lsu_awvalid), .lsu_wvalid(lsu_wvalid), .lsu_awready(lsu_awready),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_arburst(out_arburst), .out_arsatp(out_arsatp), .out_arvalid(out_arvalid),
    .out_arready(out_arready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rvalid(out_rvalid), .out_rready(out_rready),
    .out_awaddr(out_awaddr), .out_awsatp(out_awsatp), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_awvalid(out_awvalid), .out_wvalid(out_wvalid),
    .out_awready(out_awready), .out_wready(out_wready), .out_bresp(out_bresp),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .o_state(o_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered on the first cycle after a read grant: runs AR then all R beats, ends back in IDLE.
  task automatic do_ar_r(input logic is_lsu, input logic [7:0] len, input logic [31:0] addr);
    logic [31:0] d;
    #1;
    chk("ar_state", o_state, is_lsu ? 64'd3 : 64'd1);
    chk("ar_valid", out_arvalid, 1);
    chk("ar_addr", out_araddr, addr);
    chk("ar_len", out_arlen, len);
    chk("ar_burst", out_arburst, 2'b01);
    out_arready = 1'b1;
    cyc();
    out_arready = 1'b0;
    #1;
    chk("r_state", o_state, is_lsu ? 64'd4 : 64'd2);
    chk("ar_drop", out_arvalid, 0);
    for (int b = 0; b <= int'(len); b++) begin
      d = 32'hC0DE_0000 ^ 32'(b);
      out_rvalid = 1'b1;
      out_rdata  = d;
      out_rresp  = 2'b00;
      out_rlast  = (b == int'(len));
      ifu_rready = 1'b1;
      lsu_rready = 1'b1;
      #1;
      chk("r_ifu_valid", ifu_rvalid, !is_lsu);
      chk("r_lsu_valid", lsu_rvalid, is_lsu);
      chk("r_data", is_lsu ? lsu_rdata : ifu_rdata, d);
      chk("r_ready", out_rready, 1);
      cyc();
    end
    out_rvalid = 1'b0;
    out_rlast  = 1'b0;
    #1;
    chk("r_done_idle", o_state, 0);
  endtask

  logic       exp_lsu_first;
  logic [3:0] exp_seq;

  initial begin
    rst = 1'b1; satp = '0;
    ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arburst = '0; ifu_arvalid = 1'b0;
    ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    lsu_bready = 1'b0;
    out_arready = 1'b0; out_rdata = '0; out_rresp = '0; out_rlast = 1'b0; out_rvalid = 1'b0;
    out_awready = 1'b0; out_wready = 1'b0; out_bresp = '0; out_bvalid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_arvalid", out_arvalid, 0);
    chk("rst_awvalid", out_awvalid, 0);
    chk("rst_wvalid", out_wvalid, 0);
    chk("rst_araddr", out_araddr, 0);
    chk("rst_arsatp", out_arsatp, 0);
    chk("rst_wstrb", out_wstrb, 0);

    // IFU 4-beat read; satp changes after grant and must not leak into the request
    cyc();
    ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd3; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    ifu_arvalid = 1'b1; satp = 32'h8008_0000;
    #1;
    chk("ifu_arready", ifu_arready, 1);
    chk("ifu_no_lsu_ready", lsu_arready, 0);
    chk("ifu_no_out_early", out_arvalid, 0);
    cyc();
    ifu_arvalid = 1'b0; satp = 32'h1111_2222;
    #1;
    chk("ifu_arready_pulse", ifu_arready, 0);
    chk("ifu_araddr", out_araddr, 32'h8000_0000);
    chk("ifu_arsize", out_arsize, 3'd2);
    chk("ifu_arsatp", out_arsatp, 32'h8008_0000);
    cyc();
    #1;
    chk("ifu_ar_hold", out_arvalid, 1);
    chk("ifu_arsatp_hold", out_arsatp, 32'h8008_0000);
    do_ar_r(1'b0, 8'd3, 32'h8000_0000);

    // LSU write: AW alone and W alone are not eligible; W ready lags AW by 3 cycles
    cyc();
    lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    lsu_awvalid = 1'b1; satp = 32'h8008_0001;
    #1;
    chk("aw_only_ready", lsu_awready, 0);
    chk("aw_only_state", o_state, 0);
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b1;
    #1;
    chk("w_only_ready", lsu_wready, 0);
    cyc();
    lsu_awvalid = 1'b1;
    #1;
    chk("wr_awready", lsu_awready, 1);
    chk("wr_wready", lsu_wready, 1);
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; satp = '0;
    #1;
    chk("wr_state", o_state, 5);
    chk("wr_awvalid", out_awvalid, 1);
    chk("wr_wvalid", out_wvalid, 1);
    chk("wr_awaddr", out_awaddr, 32'h8000_0010);
    chk("wr_wdata", out_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", out_wstrb, 4'hF);
    chk("wr_awsatp", out_awsatp, 32'h8008_0001);
    chk("wr_awready_pulse", lsu_awready, 0);
    out_awready = 1'b1;
    cyc();
    out_awready = 1'b0;
    #1;
    chk("wr_aw_drop", out_awvalid, 0);
    chk("wr_w_hold1", out_wvalid, 1);
    cyc();
    #1;
    chk("wr_w_hold2", out_wvalid, 1);
    chk("wr_state_hold", o_state, 5);
    cyc();
    out_wready = 1'b1;
    #1;
    chk("wr_w_hold3", out_wvalid, 1);
    cyc();
    out_wready = 1'b0;
    #1;
    chk("b_state", o_state, 6);
    chk("b_w_drop", out_wvalid, 0);
    chk("b_no_valid", lsu_bvalid, 0);
    cyc();
    out_bvalid = 1'b1; out_bresp = 2'b00; lsu_bready = 1'b1;
    #1;
    chk("b_valid", lsu_bvalid, 1);
    chk("b_resp", lsu_bresp, 0);
    chk("b_ready", out_bready, 1);
    cyc();
    out_bvalid = 1'b0;
    #1;
    chk("b_idle", o_state, 0);
    chk("b_valid_drop", lsu_bvalid, 0);

    // IFU and LSU read in the same cycle; last grant was LSU (the write)
`ifdef ARB_RR_EN
    exp_lsu_first = 1'b0;
`else
    exp_lsu_first = 1'b1;
`endif
    ifu_araddr = 32'h8000_0100; ifu_arlen = 8'd1; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0200; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
    satp = 32'h8008_0002;
    #1;
    chk("cont_lsu_ready", lsu_arready, exp_lsu_first);
    chk("cont_ifu_ready", ifu_arready, !exp_lsu_first);
    cyc();
    if (exp_lsu_first) lsu_arvalid = 1'b0;
    else ifu_arvalid = 1'b0;
    #1;
    chk("cont_loser_wait", exp_lsu_first ? ifu_arready : lsu_arready, 0);
    do_ar_r(exp_lsu_first, exp_lsu_first ? 8'd0 : 8'd1,
            exp_lsu_first ? 32'h8000_0200 : 32'h8000_0100);
    chk("cont_loser_grant", exp_lsu_first ? ifu_arready : lsu_arready, 1);
    cyc();
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    do_ar_r(!exp_lsu_first, exp_lsu_first ? 8'd1 : 8'd0,
            exp_lsu_first ? 32'h8000_0100 : 32'h8000_0200);

    // Sustained contention: both masters keep requesting for four grants
`ifdef ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1111;
`endif
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("rr_lsu_ready", lsu_arready, exp_seq[r]);
      chk("rr_ifu_ready", ifu_arready, !exp_seq[r]);
      cyc();
      if (r == 3) begin
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
      end
      do_ar_r(exp_seq[r], exp_seq[r] ? 8'd0 : 8'd1,
              exp_seq[r] ? 32'h8000_0200 : 32'h8000_0100);
    end

    // Write and read in the same IDLE cycle: write completes before the read is accepted
    cyc();
    lsu_awaddr = 32'h8000_0020; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    lsu_araddr = 32'h8000_0300; lsu_arvalid = 1'b1;
    #1;
    chk("wr_rd_awready", lsu_awready, 1);
    chk("wr_rd_arready", lsu_arready, 0);
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    #1;
    chk("wr_rd_state_w", o_state, 5);
    chk("wr_rd_wstrb", out_wstrb, 4'h3);
    chk("wr_rd_hold_w", lsu_arready, 0);
    out_awready = 1'b1; out_wready = 1'b1;
    cyc();
    out_awready = 1'b0; out_wready = 1'b0;
    #1;
    chk("wr_rd_state_b", o_state, 6);
    chk("wr_rd_aw_drop", out_awvalid, 0);
    chk("wr_rd_w_drop", out_wvalid, 0);
    chk("wr_rd_hold_b", lsu_arready, 0);
    cyc();
    out_bvalid = 1'b1; out_bresp = 2'b10; lsu_bready = 1'b1;
    #1;
    chk("wr_rd_bresp", lsu_bresp, 2'b10);
    chk("wr_rd_hold_bv", lsu_arready, 0);
    cyc();
    out_bvalid = 1'b0; out_bresp = 2'b00;
    #1;
    chk("wr_rd_idle", o_state, 0);
    chk("wr_rd_ar_grant", lsu_arready, 1);
    cyc();
    lsu_arvalid = 1'b0;
    do_ar_r(1'b1, 8'd0, 32'h8000_0300);

    // Reset during an IFU burst after 2 of 4 beats, then a fresh LSU read
    cyc();
    ifu_araddr = 32'h8000_0400; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
    #1;
    chk("mr_ifu_ready", ifu_arready, 1);
    cyc();
    ifu_arvalid = 1'b0; out_arready = 1'b1;
    cyc();
    out_arready = 1'b0;
    #1;
    chk("mr_state_r", o_state, 2);
    for (int b = 0; b < 2; b++) begin
      out_rvalid = 1'b1; out_rdata = 32'h5A5A_0000 + 32'(b); out_rlast = 1'b0; ifu_rready = 1'b1;
      #1;
      chk("mr_beat", ifu_rdata, 32'h5A5A_0000 + 32'(b));
      cyc();
    end
    rst = 1'b1; out_rdata = 32'h5A5A_0002;
    cyc();
    rst = 1'b0;
    #1;
    chk("mr_state", o_state, 0);
    chk("mr_ifu_rvalid", ifu_rvalid, 0);
    chk("mr_rready", out_rready, 0);
    chk("mr_arvalid", out_arvalid, 0);
    chk("mr_awvalid", out_awvalid, 0);
    chk("mr_wvalid", out_wvalid, 0);
    out_rvalid = 1'b0;
    lsu_araddr = 32'h8000_0500; lsu_arvalid = 1'b1;
    #1;
    chk("mr_lsu_ready", lsu_arready, 1);
    cyc();
    lsu_arvalid = 1'b0;
    do_ar_r(1'b1, 8'd0, 32'h8000_0500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
